// File: rtl/vga_sync_gen_if.sv
// Timing outputs of the VGA sync generator, bundled for the compositor side.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  logic        pclk_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync;
  logic        vsync;
  logic        vga_valid;
  logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pclk_en, h_cnt, v_cnt, hsync, vsync, vga_valid, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pclk_en, h_cnt, v_cnt, hsync, vsync, vga_valid, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, registered sync/valid/frame strobes.
// Optional 16-bit frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_err
    $error("vga_sync_gen: H_TOTAL/V_TOTAL above 1024 do not fit the 10-bit counters");
  end
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_sync_gen: CLK_DIV must be 1 or more");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             pclk_en_q, pclk_en_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vga_valid_q, vga_valid_d;
  logic             frame_start_q, frame_start_d;

  // Decodes use the next counter values so the registered strobes line up with the counters.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pclk_en_d     = (div_d == DIV_LAST);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pclk_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    hsync_d     = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
    vsync_d     = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
    vga_valid_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pclk_en_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vga_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pclk_en_q     <= pclk_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vga_valid_q   <= vga_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pclk_en     = pclk_en_q;
  assign vga.h_cnt       = h_cnt_q;
  assign vga.v_cnt       = v_cnt_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.vga_valid   = vga_valid_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a tiny raster for frame-level checks, and CLK_DIV=1.
module tb_vga_sync_gen;

  localparam int W_HS  = 0;
  localparam int W_VS  = 1;
  localparam int W_VAL = 2;
  localparam int W_PE  = 3;
  localparam int W_FS  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d_n, rst_s_n, rst_1_n;
  int checks = 0;
  int errors = 0;

  vga_sync_gen_if if_d ();
  vga_sync_gen_if if_s ();
  vga_sync_gen_if if_1 ();

  vga_sync_gen u_def (.clk(clk), .rst_n(rst_d_n), .vga(if_d));

  // Tiny raster: H_TOTAL=15 (sync at 10..12), V_TOTAL=8 (sync at 5..6), 2 clk per pixel.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2)
  ) u_small (.clk(clk), .rst_n(rst_s_n), .vga(if_s));

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (.clk(clk), .rst_n(rst_1_n), .vga(if_1));

  logic       hs [3], vs [3], val [3], pe [3], fs [3];
  logic [9:0] hc [3], vc [3];

  always_comb begin
    hs[0] = if_d.hsync; vs[0] = if_d.vsync; val[0] = if_d.vga_valid;
    pe[0] = if_d.pclk_en; fs[0] = if_d.frame_start; hc[0] = if_d.h_cnt; vc[0] = if_d.v_cnt;
    hs[1] = if_s.hsync; vs[1] = if_s.vsync; val[1] = if_s.vga_valid;
    pe[1] = if_s.pclk_en; fs[1] = if_s.frame_start; hc[1] = if_s.h_cnt; vc[1] = if_s.v_cnt;
    hs[2] = if_1.hsync; vs[2] = if_1.vsync; val[2] = if_1.vga_valid;
    pe[2] = if_1.pclk_en; fs[2] = if_1.frame_start; hc[2] = if_1.h_cnt; vc[2] = if_1.v_cnt;
  end

  function automatic logic sig(input int d, input int w);
    case (w)
      W_HS:    return hs[d];
      W_VS:    return vs[d];
      W_VAL:   return val[d];
      W_PE:    return pe[d];
      default: return fs[d];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Steps until the selected signal reads lvl; n is the number of clocks taken (maxc on timeout).
  task automatic wait_val(input int d, input int w, input logic lvl, input int maxc, output int n);
    n = 0;
    while (sig(d, w) !== lvl && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic chk_state(input string tag, input int d, input int h, input int v,
                           input int h_s, input int v_s, input int vl, input int p, input int f);
    chk({tag, " h_cnt"}, hc[d], h);
    chk({tag, " v_cnt"}, vc[d], v);
    chk({tag, " hsync"}, hs[d], h_s);
    chk({tag, " vsync"}, vs[d], v_s);
    chk({tag, " vga_valid"}, val[d], vl);
    chk({tag, " pclk_en"}, pe[d], p);
    chk({tag, " frame_start"}, fs[d], f);
  endtask

  typedef struct {
    int n;   // clock edges since reset release
    int h;
    int v;
    int hs;
    int vs;
    int val;
    int pe;
    int fs;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n, n2, cnt, pulses, zeros;

    // Tiny raster: after N edges, pixel index p = N>>1, pclk_en = N odd.
    tbl[0]  = '{n:1,   h:0,  v:0, hs:1, vs:1, val:1, pe:1, fs:0};
    tbl[1]  = '{n:2,   h:1,  v:0, hs:1, vs:1, val:1, pe:0, fs:0};
    tbl[2]  = '{n:16,  h:8,  v:0, hs:1, vs:1, val:0, pe:0, fs:0};
    tbl[3]  = '{n:21,  h:10, v:0, hs:0, vs:1, val:0, pe:1, fs:0};
    tbl[4]  = '{n:25,  h:12, v:0, hs:0, vs:1, val:0, pe:1, fs:0};
    tbl[5]  = '{n:26,  h:13, v:0, hs:1, vs:1, val:0, pe:0, fs:0};
    tbl[6]  = '{n:30,  h:0,  v:1, hs:1, vs:1, val:1, pe:0, fs:0};
    tbl[7]  = '{n:150, h:0,  v:5, hs:1, vs:0, val:0, pe:0, fs:0};
    tbl[8]  = '{n:171, h:10, v:5, hs:0, vs:0, val:0, pe:1, fs:0};
    tbl[9]  = '{n:180, h:0,  v:6, hs:1, vs:0, val:0, pe:0, fs:0};
    tbl[10] = '{n:211, h:0,  v:7, hs:1, vs:1, val:0, pe:1, fs:0};
    tbl[11] = '{n:240, h:0,  v:0, hs:1, vs:1, val:1, pe:0, fs:1};
    tbl[12] = '{n:242, h:1,  v:0, hs:1, vs:1, val:1, pe:0, fs:0};

    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    rst_1_n = 1'b0;
    repeat (5) step();
    for (int d = 0; d < 3; d++) chk_state($sformatf("reset[%0d]", d), d, 0, 0, 1, 1, 0, 0, 0);
`ifdef VGA_FRAME_CNT_EN
    chk("reset frame_cnt", if_s.frame_cnt, 0);
`endif

    for (int i = 0; i < 13; i++) begin
      rst_s_n = 1'b0;
      step();
      rst_s_n = 1'b1;
      repeat (tbl[i].n) step();
      chk_state($sformatf("vec N=%0d", tbl[i].n), 1, tbl[i].h, tbl[i].v, tbl[i].hs,
                tbl[i].vs, tbl[i].val, tbl[i].pe, tbl[i].fs);
    end

    // Default timing: first cycle after release, first hsync fall, widths and periods.
    rst_d_n = 1'b1;
    step();
    chk("def first h_cnt", hc[0], 0);
    chk("def first vga_valid", val[0], 1);
    wait_val(0, W_HS, 1'b0, 5000, n);
    chk("def first hsync fall", n + 1, 656 * 4);
    wait_val(0, W_HS, 1'b1, 5000, n);
    chk("def hsync low width", n, 384);
    wait_val(0, W_HS, 1'b0, 5000, n2);
    chk("def line period", n + n2, 3200);
    wait_val(0, W_PE, 1'b1, 10, n);
    wait_val(0, W_PE, 1'b0, 10, n);
    wait_val(0, W_PE, 1'b1, 10, n2);
    chk("def pclk period", n + n2, 4);

    // Reset in the middle of a line (inside hsync) on line 1.
    n = 0;
    while (hc[0] !== 10'd700 && n < 5000) begin
      step();
      n++;
    end
    chk("def reached h700 v", vc[0], 1);
    chk("def hsync at h700", hs[0], 0);
    rst_d_n = 1'b0;
    step();
    chk("def midreset h_cnt", hc[0], 0);
    chk("def midreset v_cnt", vc[0], 0);
    chk("def midreset hsync", hs[0], 1);
    rst_d_n = 1'b1;
    wait_val(0, W_HS, 1'b0, 5000, n);
    chk("def hsync fall after midreset", n, 656 * 4);

    // Tiny raster: two frame_start pulses, pixel count and vsync width.
    rst_s_n = 1'b0;
    step();
    rst_s_n = 1'b1;
    wait_val(1, W_FS, 1'b1, 1000, n);
    chk("small first frame_start", n, 240);
`ifdef VGA_FRAME_CNT_EN
    chk("small frame_cnt first", if_s.frame_cnt, 1);
`endif
    cnt = 0;
    pulses = 0;
    for (int i = 0; i < 240; i++) begin
      if (pe[1] && val[1]) cnt++;
      if (fs[1]) pulses++;
      step();
    end
    chk("small frame_start width", pulses, 1);
    chk("small visible pixels", cnt, 32);
    chk("small second frame_start", fs[1], 1);
`ifdef VGA_FRAME_CNT_EN
    chk("small frame_cnt second", if_s.frame_cnt, 2);
`endif
    wait_val(1, W_VS, 1'b0, 1000, n);
    wait_val(1, W_VS, 1'b1, 1000, n);
    chk("small vsync low width", n, 60);

    // Reset with both syncs active.
    rst_s_n = 1'b0;
    step();
    rst_s_n = 1'b1;
    repeat (171) step();
    chk("small pre-reset vsync", vs[1], 0);
    rst_s_n = 1'b0;
    step();
    chk_state("small midreset", 1, 0, 0, 1, 1, 0, 0, 0);
    rst_s_n = 1'b1;

    // CLK_DIV=1: pclk_en constantly high, 800-clk lines.
    rst_1_n = 1'b1;
    step();
    chk("div1 first h_cnt", hc[2], 0);
    chk("div1 first vga_valid", val[2], 1);
    zeros = 0;
    for (int i = 0; i < 1000; i++) begin
      if (pe[2] !== 1'b1) zeros++;
      step();
    end
    chk("div1 pclk_en low cycles", zeros, 0);
    wait_val(2, W_HS, 1'b0, 2000, n);
    wait_val(2, W_HS, 1'b1, 2000, n);
    chk("div1 hsync low width", n, 96);
    wait_val(2, W_HS, 1'b0, 2000, n2);
    chk("div1 line period", n + n2, 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
